// File: rtl/mem_port_arbiter_if.sv
// Request/grant/ack bundle between the three memory requesters, the arbiter
// and the single-port memory array.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [2:0]        gnt;
    logic [2:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Requester/memory side: drives requests and memory read data.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output dbg_req, dbg_addr, mem_rdata,
        input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  dbg_req, dbg_addr, mem_rdata,
        output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (DM > IF > DBG) arbiter for the shared single-port memory,
// with starvation guards on IF and DBG and a parameterised read latency.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        owner_reg, owner_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [2:0]        wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0] rdata_reg;

    logic       arb_fire;
    logic [2:0] pick;
    logic [1:0] starve_req, starve_win, starve_hit;

    assign arb_fire   = (state_reg == IDLE) && (bus.if_req || bus.dm_req || bus.dbg_req);
    assign starve_req = {bus.dbg_req, bus.if_req};
    assign starve_win = {pick[2], pick[0]};

    // Index 0 guards IF, index 1 guards DBG.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_starve
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (arb_fire) begin
                    if (starve_req[gi] && !starve_win[gi])
                        cnt_next = (cnt_reg == CNT_W'(STARVE_MAX)) ? cnt_reg : cnt_reg + 1'b1;
                    else
                        cnt_next = '0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) cnt_reg <= '0;
                else      cnt_reg <= cnt_next;
            end

            assign starve_hit[gi] = starve_req[gi] && (cnt_reg == CNT_W'(STARVE_MAX));
        end
    endgenerate

    // A starved IF beats a starved DBG; otherwise the default order applies.
    always_comb begin
        pick = 3'b000;
        if (starve_hit[0])    pick = 3'b001;
        else if (starve_hit[1]) pick = 3'b100;
        else if (bus.dm_req)  pick = 3'b010;
        else if (bus.if_req)  pick = 3'b001;
        else if (bus.dbg_req) pick = 3'b100;
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        addr_next     = addr_reg;
        we_next       = we_reg;
        wdata_next    = wdata_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_fire) begin
                    owner_next = pick;
                    addr_next  = pick[1] ? bus.dm_addr : (pick[0] ? bus.if_addr : bus.dbg_addr);
                    we_next    = pick[1] && bus.dm_we;
                    wdata_next = pick[1] ? bus.dm_wdata : '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = 3'd1;
                state_next    = (MEM_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (wait_cnt_reg == 3'(MEM_LAT - 1)) state_next = CAPTURE;
                else wait_cnt_next = wait_cnt_reg + 3'd1;
            end
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            owner_reg    <= 3'b000;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            wait_cnt_reg <= 3'd0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            addr_reg     <= addr_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg == CAPTURE) rdata_reg <= bus.mem_rdata;
        end
    end

    // Memory bus is only driven during ISSUE so it reads as idle otherwise.
    assign bus.gnt       = (state_reg != IDLE) ? owner_reg : 3'b000;
    assign bus.ack       = (state_reg == DONE) ? owner_reg : 3'b000;
    assign bus.rdata     = rdata_reg;
    assign bus.mem_en    = (state_reg == ISSUE);
    assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
    assign bus.mem_addr  = (state_reg == ISSUE) ? addr_reg : '0;
    assign bus.mem_wdata = (state_reg == ISSUE) ? wdata_reg : '0;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1 and one
// at MEM_LAT=3, each backed by a behavioural memory with matching latency.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        chk;
        logic [2:0]  ack;
        logic [15:0] rdata;
    } exp_t;

    logic clk;
    logic rst1, rst3;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb1[$];
    exp_t sb3[$];

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3();

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));
    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] a);
        if (a == 8'h04) return 16'hBEEF;
        return {a ^ 8'hA5, a};
    endfunction

    // Behavioural memories; contents are reloaded while the matching reset is low.
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (!rst1) begin
            for (int i = 0; i < 256; i++) mem1[i] <= pat(8'(i));
        end else if (b1.mem_en && b1.mem_we) begin
            mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
        end
        pipe1 <= mem1[b1.mem_addr[7:0]];
    end
    assign b1.mem_rdata = pipe1;

    always @(posedge clk) begin
        if (!rst3) begin
            for (int i = 0; i < 256; i++) mem3[i] <= pat(8'(i));
        end else if (b3.mem_en && b3.mem_we) begin
            mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
        end
        pipe3[0] <= mem3[b3.mem_addr[7:0]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b3.mem_rdata = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Completion monitors: every ack pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (b1.ack != 3'b000) begin
            $display("txn dut1 ack=%b rdata=%h t=%0t", b1.ack, b1.rdata, $time);
            if (sb1.size() == 0) begin
                check("sb1_unexpected_ack", 32'(b1.ack), 0);
            end else begin
                e = sb1.pop_front();
                check("sb1_ack", 32'(b1.ack), 32'(e.ack));
                check("sb1_gnt", 32'(b1.gnt), 32'(e.ack));
                if (e.chk) check("sb1_rdata", 32'(b1.rdata), 32'(e.rdata));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b3.ack != 3'b000) begin
            $display("txn dut3 ack=%b rdata=%h t=%0t", b3.ack, b3.rdata, $time);
            if (sb3.size() == 0) begin
                check("sb3_unexpected_ack", 32'(b3.ack), 0);
            end else begin
                e = sb3.pop_front();
                check("sb3_ack", 32'(b3.ack), 32'(e.ack));
                if (e.chk) check("sb3_rdata", 32'(b3.rdata), 32'(e.rdata));
            end
        end
    end

    task automatic wait_ack1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b1.ack != 3'b000) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_en1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b1.mem_en) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack3(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b3.ack != 3'b000) begin ok = 1'b1; break; end
        end
    endtask

    // who: 0=IF, 1=DM, 2=DBG. Called at a negedge with the DUT idle.
    task automatic txn1(input int who, input logic [15:0] addr, input logic we,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
        bit   ok;
        exp_t e;
        e.chk = !we; e.ack = 3'b001 << who; e.rdata = exp_rd;
        sb1.push_back(e);
        case (who)
            0: begin b1.if_req = 1'b1; b1.if_addr = addr; end
            1: begin b1.dm_req = 1'b1; b1.dm_addr = addr; b1.dm_we = we; b1.dm_wdata = wd; end
            default: begin b1.dbg_req = 1'b1; b1.dbg_addr = addr; end
        endcase
        wait_ack1(ok);
        check(tag, 32'(ok), 1);
        b1.if_req = 1'b0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dbg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic txn3(input int who, input logic [15:0] addr, input logic [15:0] exp_rd,
                        input string tag);
        bit   ok;
        exp_t e;
        e.chk = 1'b1; e.ack = 3'b001 << who; e.rdata = exp_rd;
        sb3.push_back(e);
        case (who)
            0: begin b3.if_req = 1'b1; b3.if_addr = addr; end
            1: begin b3.dm_req = 1'b1; b3.dm_addr = addr; b3.dm_we = 1'b0; end
            default: begin b3.dbg_req = 1'b1; b3.dbg_addr = addr; end
        endcase
        wait_ack3(ok);
        check(tag, 32'(ok), 1);
        b3.if_req = 1'b0; b3.dm_req = 1'b0; b3.dbg_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit   ok;
        exp_t e;
        int   exp_w [6];
        exp_w = '{2, 2, 2, 2, 4, 2};

        rst1 = 1'b0; rst3 = 1'b0;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0;
        b1.dm_wdata = 0; b1.dbg_req = 0; b1.dbg_addr = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = 0;
        b3.dm_wdata = 0; b3.dbg_req = 0; b3.dbg_addr = 0;
        repeat (3) @(negedge clk);

        check("rst_gnt",    32'(b1.gnt), 0);
        check("rst_ack",    32'(b1.ack), 0);
        check("rst_busy",   32'(b1.busy), 0);
        check("rst_mem_en", 32'(b1.mem_en), 0);
        check("rst_rdata",  32'(b1.rdata), 0);
        check("rst3_busy",  32'(b3.busy), 0);
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        // IF read of 0x0004 at MEM_LAT=1.
        e = '{chk: 1'b1, ack: 3'b001, rdata: 16'hBEEF};
        sb1.push_back(e);
        b1.if_addr = 16'h0004; b1.if_req = 1'b1;
        @(negedge clk);
        check("t1_c1_gnt",  32'(b1.gnt), 1);
        check("t1_c1_en",   32'(b1.mem_en), 1);
        check("t1_c1_addr", 32'(b1.mem_addr), 32'h0004);
        check("t1_c1_we",   32'(b1.mem_we), 0);
        @(negedge clk);
        check("t1_c2_gnt",  32'(b1.gnt), 1);
        check("t1_c2_en",   32'(b1.mem_en), 0);
        check("t1_c2_ack",  32'(b1.ack), 0);
        @(negedge clk);
        check("t1_c3_gnt",  32'(b1.gnt), 1);
        check("t1_c3_ack",  32'(b1.ack), 1);
        check("t1_c3_rdata", 32'(b1.rdata), 32'hBEEF);
        b1.if_req = 1'b0;
        @(negedge clk);
        check("t1_c4_busy", 32'(b1.busy), 0);

        // Simultaneous IF read and DM write: DM first.
        e = '{chk: 1'b0, ack: 3'b010, rdata: 16'h0000};
        sb1.push_back(e);
        e = '{chk: 1'b1, ack: 3'b001, rdata: pat(8'h30)};
        sb1.push_back(e);
        b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 16'h0010; b1.dm_wdata = 16'h1234;
        b1.if_req = 1'b1; b1.if_addr = 16'h0030;
        @(negedge clk);
        check("t2_gnt_dm",  32'(b1.gnt), 2);
        check("t2_mem_we",  32'(b1.mem_we), 1);
        check("t2_addr",    32'(b1.mem_addr), 32'h0010);
        check("t2_wdata",   32'(b1.mem_wdata), 32'h1234);
        @(negedge clk);
        @(negedge clk);
        check("t2_ack_dm",  32'(b1.ack), 2);
        b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        @(negedge clk);
        check("t2_idle",    32'(b1.busy), 0);
        @(negedge clk);
        check("t2_gnt_if",  32'(b1.gnt), 1);
        check("t2_if_addr", 32'(b1.mem_addr), 32'h0030);
        check("t2_if_we",   32'(b1.mem_we), 0);
        wait_ack1(ok);
        check("t2_if_done", 32'(ok), 1);
        b1.if_req = 1'b0;
        @(negedge clk);
        check("t2_mem_written", 32'(mem1[8'h10]), 32'h1234);

        // DM held high against DBG: four DM wins, then DBG, then DM again.
        for (int k = 0; k < 6; k++) begin
            e = '{chk: 1'b1, ack: (k == 4) ? 3'b100 : 3'b010,
                  rdata: (k == 4) ? pat(8'h50) : pat(8'h40)};
            sb1.push_back(e);
        end
        b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'h0040;
        b1.dbg_req = 1'b1; b1.dbg_addr = 16'h0050;
        for (int k = 0; k < 6; k++) begin
            wait_en1(ok);
            check("t3_issue", 32'(ok), 1);
            check("t3_winner", 32'(b1.gnt), 32'(exp_w[k]));
            if (k >= 4) begin
                wait_ack1(ok);
                check("t3_ack", 32'(ok), 1);
                if (k == 4) b1.dbg_req = 1'b0;
                else        b1.dm_req  = 1'b0;
            end
        end
        @(negedge clk);

        // DM write then DBG read of the same location.
        txn1(1, 16'h0008, 1'b1, 16'h00AA, 16'h0000, "t6_wr");
        txn1(2, 16'h0008, 1'b0, 16'h0000, 16'h00AA, "t6_dbg_rd");

        // MEM_LAT=3 read of 0x0020.
        e = '{chk: 1'b1, ack: 3'b001, rdata: pat(8'h20)};
        sb3.push_back(e);
        b3.if_addr = 16'h0020; b3.if_req = 1'b1;
        @(negedge clk);
        check("t4_c1_en",   32'(b3.mem_en), 1);
        check("t4_c1_addr", 32'(b3.mem_addr), 32'h0020);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("t4_wait_ack", 32'(b3.ack), 0);
            check("t4_wait_gnt", 32'(b3.gnt), 1);
            check("t4_wait_en",  32'(b3.mem_en), 0);
        end
        @(negedge clk);
        check("t4_c5_ack", 32'(b3.ack), 1);
        b3.if_req = 1'b0;
        @(negedge clk);

        // Reset asserted while waiting on the memory.
        b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 16'h0021;
        @(negedge clk);
        check("t5_issue", 32'(b3.mem_en), 1);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        check("t5_rst_gnt",   32'(b3.gnt), 0);
        check("t5_rst_busy",  32'(b3.busy), 0);
        check("t5_rst_en",    32'(b3.mem_en), 0);
        check("t5_rst_ack",   32'(b3.ack), 0);
        check("t5_rst_rdata", 32'(b3.rdata), 0);
        b3.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t5_no_ack", 32'(b3.ack), 0);
        end
        txn3(2, 16'h0022, pat(8'h22), "t5_fresh");

        repeat (3) @(negedge clk);
        check("sb1_drained", 32'(sb1.size()), 0);
        check("sb3_drained", 32'(sb3.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit unified memory between three requesters: instruction fetch (IF), data access (DM) and the debug/test read port (DBG).
- Sits between the processor datapath and the memory array. It replaces the direct address mux with a request/grant/ack handshake.
- Uses a fixed-priority scheme with a starvation guard, and supports a parameterised memory read latency.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..7.
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting IF or DBG requester is forced to win.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; read only.
- if_addr  in  ADDR_W  fetch address.
- dm_req  in  1  data request.
- dm_we  in  1  data request is a write.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug address.
- gnt  out  3  one-hot owner {dbg, dm, if}; 0 when idle.
- ack  out  3  one-hot, one-cycle completion pulse {dbg, dm, if}.
- rdata  out  DATA_W  read data; valid in the ack cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy and both starvation counters go to 0.
  - Reset mid-transaction abandons the access; no ack is issued after reset releases.
- State machine (IDLE, ISSUE, WAIT, CAPTURE, DONE):
  - IDLE: if any req is high, latch winner, address, we and wdata; go to ISSUE. Otherwise stay.
  - ISSUE: exactly one cycle. mem_en=1, mem_addr and mem_wdata from the latch, mem_we=latched we (DM only; IF and DBG force 0). Go to WAIT if MEM_LAT>1, else CAPTURE.
  - WAIT: held for MEM_LAT-1 cycles, counted by a 3-bit counter; then go to CAPTURE.
  - CAPTURE: rdata <= mem_rdata; go to DONE.
  - DONE: ack[owner]=1 for one cycle; no arbitration this cycle; go to IDLE.
- Grant timing: gnt[owner] is high from ISSUE through DONE inclusive.
- Latency: for MEM_LAT=1, request sampled in IDLE at cycle 0 gives mem_en at cycle 1 and ack at cycle 3. In general, ack comes MEM_LAT+2 cycles after the sampling cycle, and the back-to-back period is MEM_LAT+3.
- Writes take the same path. rdata is captured but meaningless; ack acknowledges the write.
- Arbitration, evaluated only in IDLE:
  - Default priority is DM > IF > DBG.
  - A requester whose counter equals STARVE_MAX overrides the default. If both IF and DBG are starved, IF wins.
- Starvation counters (IF and DBG only), updated at each arbitration decision:
  - Increment, saturating at STARVE_MAX, when the requester is asserting req and loses.
  - Clear when it wins or when its req is low.
- Requester protocol:
  - req, addr, we and wdata stay stable until ack.
  - The arbiter samples inputs only in IDLE and uses latched copies afterwards.
  - Dropping req early does not cancel the access: the access completes and ack still pulses.
- rdata holds its last captured value between transactions.
- ack and gnt are never non-zero for more than one requester at a time.

Test Plan:
- MEM_LAT=1; if_req with if_addr=0x0004 at cycle 0 and mem_rdata=0xBEEF -> gnt=3'b001 on cycles 1–3, mem_en on cycle 1 only with mem_addr=0x0004, ack=3'b001 with rdata=0xBEEF on cycle 3, busy=0 on cycle 4.
- Simultaneous if_req and dm_req (dm_we=1, dm_addr=0x0010, dm_wdata=0x1234) -> DM served first with mem_we=1 and mem_wdata=0x1234 at ISSUE; IF granted in the IDLE following DM's DONE.
- dm_req held high continuously, dbg_req high, STARVE_MAX=4 -> DM wins 4 arbitrations, DBG wins the 5th, then DM resumes.
- MEM_LAT=3, read 0x0020 -> mem_en at cycle 1, WAIT on cycles 2–3, CAPTURE on cycle 4, ack on cycle 5.
- MEM_LAT=3; rst driven low during WAIT -> all outputs 0 immediately (asynchronous); after release, no ack; a fresh request completes normally.
- DM write 0x00AA to 0x0008, then DBG read of 0x0008 against a behavioural memory -> dbg ack with rdata=0x00AA.
